// File: rtl/usb_fs_in_arb_seq_if.sv
// rtl/usb_fs_in_arb_seq_if.sv - IN-endpoint buffer arbitration bus between endpoints and IN protocol engine
interface usb_fs_in_arb_seq_if #(
  parameter int NUM_IN_EPS = 1
);
  localparam int IDX_W = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;

  logic [NUM_IN_EPS-1:0]   in_ep_req;
  logic [NUM_IN_EPS-1:0]   in_ep_grant;
  logic [NUM_IN_EPS-1:0]   in_ep_data_put;
  logic [8*NUM_IN_EPS-1:0] in_ep_data;
  logic [NUM_IN_EPS-1:0]   in_ep_data_done;
  logic                    arb_in_ep_data_put;
  logic [7:0]              arb_in_ep_data;
  logic                    arb_in_ep_data_done;
  logic [IDX_W-1:0]        arb_grant_idx;
  logic                    arb_busy;

  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done,
    input  in_ep_grant, arb_in_ep_data_put, arb_in_ep_data, arb_in_ep_data_done,
    input  arb_grant_idx, arb_busy
  );

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done,
    output in_ep_grant, arb_in_ep_data_put, arb_in_ep_data, arb_in_ep_data_done,
    output arb_grant_idx, arb_busy
  );
endinterface

// File: rtl/usb_fs_in_arb_seq.sv
// rtl/usb_fs_in_arb_seq.sv - packet-locked IN buffer arbiter; USB_IN_ARB_ROUND_ROBIN_EN selects rotating priority
module usb_fs_in_arb_seq #(
  parameter int NUM_IN_EPS      = 1,
  parameter int MAX_HOLD_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  usb_fs_in_arb_seq_if.slave  io_arb
);
  localparam int IDX_W  = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam int HOLD_W = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_IN_EPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_IN_EPS-1:0] r_grant;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic [HOLD_W-1:0]     r_hold;

  logic                  w_put;
  logic [7:0]            w_data;
  logic                  w_done;
  logic                  w_req;
  logic                  w_found;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_timeout;
  logic                  w_release;

  // Grant is one-hot, so OR-ing over the granted bit is the gated mux.
  always_comb begin
    w_put  = 1'b0;
    w_data = 8'h00;
    w_done = 1'b0;
    w_req  = 1'b0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (r_grant[i]) begin
        w_put  = io_arb.in_ep_data_put[i];
        w_data = io_arb.in_ep_data[8*i +: 8];
        w_done = io_arb.in_ep_data_done[i];
        w_req  = io_arb.in_ep_req[i];
      end
    end
  end

  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < NUM_IN_EPS; k++) begin
      int j;
      j = (int'(r_ptr) + k) % NUM_IN_EPS;
      if (!w_found && io_arb.in_ep_req[j]) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'(j);
      end
    end
  end

  assign w_timeout = (MAX_HOLD_CYCLES != 0) && (r_hold == HOLD_MAX);
  assign w_release = !w_req || w_done || w_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            for (int i = 0; i < NUM_IN_EPS; i++) begin
              r_grant[i] <= (w_win_idx == IDX_W'(i));
            end
            r_idx  <= w_win_idx;
            r_hold <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state <= ST_RELEASE;
            r_grant <= '0;
          end
          if (w_put) begin
            r_hold <= '0;
          end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
`ifdef USB_IN_ARB_ROUND_ROBIN_EN
          r_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
`else
          r_ptr <= '0;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign io_arb.in_ep_grant         = r_grant;
  assign io_arb.arb_in_ep_data_put  = w_put;
  assign io_arb.arb_in_ep_data      = w_data;
  assign io_arb.arb_in_ep_data_done = w_done;
  assign io_arb.arb_grant_idx       = r_idx;
  assign io_arb.arb_busy            = (r_state != ST_IDLE);
endmodule

// File: tb/tb_usb_fs_in_arb_seq.sv
// tb/tb_usb_fs_in_arb_seq.sv - self-checking bench for usb_fs_in_arb_seq (4 EPs, hold limit 4)
module tb_usb_fs_in_arb_seq;
  localparam int N    = 4;
  localparam int MAXH = 4;
`ifdef USB_IN_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_fs_in_arb_seq_if #(.NUM_IN_EPS(N)) bus();

  usb_fs_in_arb_seq #(.NUM_IN_EPS(N), .MAX_HOLD_CYCLES(MAXH)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_arb    (bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] put,
                       input logic [3:0] done, input logic [31:0] data);
    bus.in_ep_req       = req;
    bus.in_ep_data_put  = put;
    bus.in_ep_data_done = done;
    bus.in_ep_data      = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  put;
    logic [3:0]  done;
    logic [31:0] data;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic [1:0]  e_idx;
    logic        e_put;
    logic [7:0]  e_data;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  // random-phase reference state
  int mg, gap, ptr, since, midx, last;

  initial begin
    // reset held with everything asserted, then latency / data path / done release / re-grant
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 4'hF, 4'hF, 4'hF, 32'hFFFFFFFF, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 32'h00A50000, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA5, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 32'h005A0000, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h5A, 1'b0});
    tbl.push_back('{1'b1, 4'b0101, 4'b0101, 4'b0100, 32'h003C00FF, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h3C, 1'b1});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0001, 4'b1001, 4'b0000, 32'h99000011, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h11, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0});

    do_reset();
    foreach (tbl[r]) begin
      rst_n = tbl[r].rst_n;
      drive(tbl[r].req, tbl[r].put, tbl[r].done, tbl[r].data);
      #1;
      chk($sformatf("tbl%0d grant", r), 32'(bus.in_ep_grant), 32'(tbl[r].e_grant));
      chk($sformatf("tbl%0d busy", r), 32'(bus.arb_busy), 32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d idx", r), 32'(bus.arb_grant_idx), 32'(tbl[r].e_idx));
      chk($sformatf("tbl%0d put", r), 32'(bus.arb_in_ep_data_put), 32'(tbl[r].e_put));
      chk($sformatf("tbl%0d data", r), 32'(bus.arb_in_ep_data), 32'(tbl[r].e_data));
      chk($sformatf("tbl%0d done", r), 32'(bus.arb_in_ep_data_done), 32'(tbl[r].e_done));
      tick();
    end

    // priority order with req=1011 held and one put+done per grant
    begin
      int got[4];
      int exp_ord[4];
      int n = 0;
      exp_ord = RR ? '{0, 1, 3, 0} : '{0, 0, 0, 0};
      do_reset();
      drive(4'b1011, 4'h0, 4'h0, 32'h0);
      for (int c = 0; c < 60 && n < 4; c++) begin
        if (bus.in_ep_grant != 4'h0) begin
          int g;
          g = onehot_idx(bus.in_ep_grant);
          got[n] = g;
          n++;
          drive(4'b1011, 4'(1 << g), 4'(1 << g), 32'(8'h40 + g) << (8 * g));
          #1;
          chk("prio put+done put", 32'(bus.arb_in_ep_data_put), 32'd1);
          chk("prio put+done done", 32'(bus.arb_in_ep_data_done), 32'd1);
          chk("prio data", 32'(bus.arb_in_ep_data), 32'(8'h40 + g));
          tick();
          drive(4'b1011, 4'h0, 4'h0, 32'h0);
        end else begin
          tick();
        end
      end
      chk("prio grant count", 32'(n), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("prio order%0d", i), 32'(got[i]), 32'(exp_ord[i]));
    end

    // stalled grant revoked; foreign put ignored
    begin
      int w = 0;
      int hi = 0;
      do_reset();
      drive(4'b0010, 4'b1000, 4'h0, 32'hC3000000);
      while (bus.in_ep_grant != 4'b0010 && w < 10) begin
        tick();
        w++;
      end
      chk("timeout granted", 32'(bus.in_ep_grant), 32'h2);
      while (bus.in_ep_grant == 4'b0010 && hi < 20) begin
        chk("timeout foreign put", 32'(bus.arb_in_ep_data_put), 32'd0);
        tick();
        hi++;
      end
      chk("timeout hold cycles", 32'(hi), 32'(MAXH + 1));
      chk("timeout release grant", 32'(bus.in_ep_grant), 32'h0);
      chk("timeout release busy", 32'(bus.arb_busy), 32'd1);
    end

    // reset in the middle of a packet
    begin
      int w = 0;
      do_reset();
      drive(4'b0100, 4'h0, 4'h0, 32'h0);
      while (bus.in_ep_grant != 4'b0100 && w < 10) begin
        tick();
        w++;
      end
      chk("midrst granted", 32'(bus.in_ep_grant), 32'h4);
      drive(4'b0100, 4'b0100, 4'h0, 32'h00770000);
      tick();
      rst_n = 1'b0;
      drive(4'b0100, 4'h0, 4'h0, 32'h0);
      tick();
      chk("midrst grant", 32'(bus.in_ep_grant), 32'h0);
      chk("midrst busy", 32'(bus.arb_busy), 32'd0);
      drive(4'b0100, 4'b0100, 4'b0100, 32'h00880000);
      #1;
      chk("midrst done", 32'(bus.arb_in_ep_data_done), 32'd0);
      chk("midrst put", 32'(bus.arb_in_ep_data_put), 32'd0);
      tick();
      rst_n = 1'b1;
    end

    // randomized traffic against a cycle-level reference of the arbitration rules
    do_reset();
    mg = -1; gap = 0; ptr = 0; since = 0; midx = 0; last = 0;
    begin
      logic [3:0] req = 4'h0;
      for (int c = 0; c < 3000; c++) begin
        logic [3:0]  put, done, eg;
        logic [31:0] data;
        logic        ep, edn;
        logic [7:0]  ed;
        for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        put  = 4'($urandom);
        done = 4'h0;
        for (int i = 0; i < N; i++) done[i] = ($urandom_range(0, 11) == 0);
        data = $urandom;
        rst_n = ($urandom_range(0, 299) != 0);
        drive(req, put, done, data);
        #1;
        eg  = (mg >= 0) ? 4'(1 << mg) : 4'h0;
        ep  = (mg >= 0) ? put[mg] : 1'b0;
        edn = (mg >= 0) ? done[mg] : 1'b0;
        ed  = (mg >= 0) ? 8'(data >> (8 * mg)) : 8'h00;
        chk("rnd grant", 32'(bus.in_ep_grant), 32'(eg));
        chk("rnd busy", 32'(bus.arb_busy), 32'((mg >= 0) || (gap != 0)));
        chk("rnd idx", 32'(bus.arb_grant_idx), 32'(midx));
        chk("rnd put", 32'(bus.arb_in_ep_data_put), 32'(ep));
        chk("rnd data", 32'(bus.arb_in_ep_data), 32'(ed));
        chk("rnd done", 32'(bus.arb_in_ep_data_done), 32'(edn));
        if (!rst_n) begin
          mg = -1; gap = 0; ptr = 0; since = 0; midx = 0;
        end else if (mg >= 0) begin
          bit rel;
          rel = !req[mg] || done[mg] || (since == MAXH);
          since = put[mg] ? 0 : ((since < MAXH) ? since + 1 : since);
          if (rel) begin
            last = mg;
            mg = -1;
            gap = 1;
          end
        end else if (gap != 0) begin
          gap = 0;
          ptr = RR ? (last + 1) % N : 0;
        end else if (req != 4'h0) begin
          for (int k = N - 1; k >= 0; k--) if (req[(ptr + k) % N]) mg = (ptr + k) % N;
          midx = mg;
          since = 0;
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
